am4_mcseq: RTL and testbench

//   Am2910-class microprogram sequencer for the M4 core. Produces the 10-bit

---
 rtl/am4_mcseq.sv | 150 +++++++++++++++
 tb/tb_am4_mcseq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/am4_mcseq.sv
// Am2910-class microprogram sequencer: next microaddress, microPC, loop counter and LIFO stack.
// Optional sticky stack error output enabled by defining AM4_MCSEQ_STKERR_EN.
module am4_mcseq #(
    parameter int unsigned AW          = 10,
    parameter int unsigned STACK_DEPTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [3:0]    inst,
    input  logic [AW-1:0] d,
    input  logic          cc_n,
    input  logic          ccen_n,
    input  logic          rld_n,
    input  logic          ci,
    output logic [AW-1:0] y,
    output logic          pl_n,
    output logic          map_n,
    output logic          vect_n,
`ifdef AM4_MCSEQ_STKERR_EN
    output logic          stk_err,
`endif
    output logic          full_n
);

    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

    typedef enum logic [3:0] {
        I_JZ, I_CJS, I_JMAP, I_CJP, I_PUSH, I_JSRP, I_CJV, I_JRP,
        I_RFCT, I_RPCT, I_CRTN, I_CJPP, I_LDCT, I_LOOP, I_CONT, I_TWB
    } op_e;

    logic [AW-1:0]  upc_q, upc_d;
    logic [AW-1:0]  r_q, r_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  stack_q [STACK_DEPTH];
    logic [AW-1:0]  stack_d [STACK_DEPTH];
    logic           err_q, err_d;

    op_e           op;
    logic          pass, rz, full, empty;
    logic [AW-1:0] tos;
    logic          push, pop, r_dec, r_ld, sp_clr;

    assign op    = rst_n ? op_e'(inst) : I_JZ;
    assign pass  = ccen_n | ~cc_n;
    assign rz    = (r_q == '0);
    assign full  = (sp_q == SPW'(STACK_DEPTH));
    assign empty = (sp_q == '0);
    assign full_n = ~full;

    // Top of stack; reads zero when the stack is empty.
    always_comb begin
        tos = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (SPW'(i + 1) == sp_q) tos = stack_q[i];
        end
    end

    // Instruction decode: next address, source selects and stack/counter actions.
    always_comb begin
        y      = upc_q;
        pl_n   = 1'b0;
        map_n  = 1'b1;
        vect_n = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        r_dec  = 1'b0;
        r_ld   = 1'b0;
        sp_clr = 1'b0;
        case (op)
            I_JZ:   begin y = '0; sp_clr = 1'b1; end
            I_CJS:  if (pass) begin y = d; push = 1'b1; end
            I_JMAP: begin y = d; map_n = 1'b0; pl_n = 1'b1; end
            I_CJP:  if (pass) y = d;
            I_PUSH: begin push = 1'b1; r_ld = pass; end
            I_JSRP: begin push = 1'b1; y = pass ? d : r_q; end
            I_CJV:  begin vect_n = 1'b0; pl_n = 1'b1; if (pass) y = d; end
            I_JRP:  y = pass ? d : r_q;
            I_RFCT: if (!rz) begin y = tos; r_dec = 1'b1; end else pop = 1'b1;
            I_RPCT: if (!rz) begin y = d; r_dec = 1'b1; end
            I_CRTN: if (pass) begin y = tos; pop = 1'b1; end
            I_CJPP: if (pass) begin y = d; pop = 1'b1; end
            I_LDCT: r_ld = 1'b1;
            I_LOOP: if (pass) pop = 1'b1; else y = tos;
            I_CONT: ;
            I_TWB: begin
                pop = 1'b1;
                if (!rz) begin
                    if (!pass) begin y = tos; r_dec = 1'b1; pop = 1'b0; end
                end else if (!pass) begin
                    y = d;
                end
            end
            default: ;
        endcase
    end

    // Next-state: microPC, counter, stack pointer/contents and sticky error.
    always_comb begin
        upc_d   = upc_q;
        r_d     = r_q;
        sp_d    = sp_q;
        stack_d = stack_q;
        err_d   = err_q;
        if (ena) begin
            upc_d = y + AW'(ci);
            if (!rld_n || r_ld) r_d = d;
            else if (r_dec)     r_d = r_q - AW'(1);
            if (sp_clr) begin
                sp_d  = '0;
                err_d = 1'b0;
            end else if (push) begin
                // When full the new entry overwrites TOS instead of growing.
                for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                    if ((full ? SPW'(i + 1) : SPW'(i)) == sp_q) stack_d[i] = upc_q;
                end
                if (!full) sp_d = sp_q + SPW'(1);
                else       err_d = 1'b1;
            end else if (pop) begin
                if (!empty) sp_d = sp_q - SPW'(1);
                else        err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_q   <= '0;
            r_q     <= '0;
            sp_q    <= '0;
            stack_q <= '{default: '0};
            err_q   <= 1'b0;
        end else begin
            upc_q   <= upc_d;
            r_q     <= r_d;
            sp_q    <= sp_d;
            stack_q <= stack_d;
            err_q   <= err_d;
        end
    end

`ifdef AM4_MCSEQ_STKERR_EN
    assign stk_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_am4_mcseq.sv
// Directed self-checking bench for am4_mcseq with hand-computed next addresses.
module tb_am4_mcseq;

    logic       clk = 1'b0;
    logic       rst_n, ena, cc_n, ccen_n, rld_n, ci;
    logic [3:0] inst;
    logic [9:0] d, y;
    logic       pl_n, map_n, vect_n, full_n;
`ifdef AM4_MCSEQ_STKERR_EN
    logic       stk_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    am4_mcseq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .inst   (inst),
        .d      (d),
        .cc_n   (cc_n),
        .ccen_n (ccen_n),
        .rld_n  (rld_n),
        .ci     (ci),
        .y      (y),
        .pl_n   (pl_n),
        .map_n  (map_n),
        .vect_n (vect_n),
`ifdef AM4_MCSEQ_STKERR_EN
        .stk_err(stk_err),
`endif
        .full_n (full_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] op, input logic [9:0] dv, input logic ccn);
        inst = op;
        d    = dv;
        cc_n = ccn;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ci = 1'b1; rld_n = 1'b1;
        ccen_n = 1'b1; cc_n = 1'b1; d = '0; inst = 4'd14;
        #2;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_full_n", 32'(full_n), 32'h1);
        chk("rst_pl_n", 32'(pl_n), 32'h0);
        chk("rst_map_n", 32'(map_n), 32'h1);
        chk("rst_vect_n", 32'(vect_n), 32'h1);
`ifdef AM4_MCSEQ_STKERR_EN
        chk("rst_stk_err", 32'(stk_err), 32'h0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        #1;

        // Sequential CONT from reset
        for (int k = 0; k < 4; k++) begin
            chk("cont_y", 32'(y), 32'(k));
            if (k < 3) tick();
        end
        chk("cont_pl_n", 32'(pl_n), 32'h0);
        repeat (2) tick();                      // upc = 5

        // Subroutine call and return
        ccen_n = 1'b0;
        set(4'd1, 10'h100, 1'b0);
        chk("cjs_y", 32'(y), 32'h100);
        tick();
        set(4'd10, 10'h0, 1'b0);
        chk("crtn_y", 32'(y), 32'h5);
        tick();                                 // upc = 6, sp = 0
        chk("crtn_empty_tos", 32'(y), 32'h0);
        set(4'd1, 10'h100, 1'b1);
        chk("cjs_fail_y", 32'(y), 32'h6);

        // LDCT then RPCT repeat loop
        set(4'd12, 10'd3, 1'b1);
        chk("ldct_y", 32'(y), 32'h6);
        tick();                                 // r = 3, upc = 7
        set(4'd9, 10'h20, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("rpct_loop_y", 32'(y), 32'h20);
            tick();
        end
        chk("rpct_exit_y", 32'(y), 32'h21);
        tick();                                 // upc = 0x22

        // Stack overflow
        for (int k = 0; k < 6; k++) begin
            set(4'd1, 10'(32'h40 + 32'h10 * k), 1'b0);
            chk("ovf_full_n", 32'(full_n), (k < 5) ? 32'h1 : 32'h0);
            tick();
        end
        chk("ovf_full_n_end", 32'(full_n), 32'h0);
`ifdef AM4_MCSEQ_STKERR_EN
        chk("ovf_stk_err", 32'(stk_err), 32'h1);
`endif
        set(4'd10, 10'h0, 1'b0);
        chk("ovf_tos", 32'(y), 32'h81);
        tick();
        chk("ovf_pop_full_n", 32'(full_n), 32'h1);
        chk("ovf_tos2", 32'(y), 32'h61);
        set(4'd0, 10'h0, 1'b0);
        chk("jz_y", 32'(y), 32'h0);
        tick();                                 // upc = 1, sp = 0
        chk("jz_full_n", 32'(full_n), 32'h1);
`ifdef AM4_MCSEQ_STKERR_EN
        chk("jz_stk_err", 32'(stk_err), 32'h0);
`endif
        set(4'd10, 10'h0, 1'b0);
        chk("jz_empty_tos", 32'(y), 32'h0);

        // PUSH with counter load, then RFCT loop
        ccen_n = 1'b1;
        set(4'd4, 10'd2, 1'b1);
        chk("push_y", 32'(y), 32'h1);
        tick();                                 // sp = 1, r = 2, upc = 2
        set(4'd8, 10'h0, 1'b1);
        chk("rfct_y0", 32'(y), 32'h1);
        tick();
        chk("rfct_y1", 32'(y), 32'h1);
        tick();
        chk("rfct_exit", 32'(y), 32'h2);
        tick();                                 // pop, upc = 3
        ccen_n = 1'b0;
        set(4'd10, 10'h0, 1'b0);
        chk("rfct_popped", 32'(y), 32'h0);

        // Source selects
        set(4'd2, 10'h155, 1'b1);
        chk("jmap_y", 32'(y), 32'h155);
        chk("jmap_map_n", 32'(map_n), 32'h0);
        chk("jmap_pl_n", 32'(pl_n), 32'h1);
        chk("jmap_vect_n", 32'(vect_n), 32'h1);
        set(4'd6, 10'h155, 1'b0);
        chk("cjv_vect_n", 32'(vect_n), 32'h0);
        chk("cjv_pl_n", 32'(pl_n), 32'h1);
        chk("cjv_map_n", 32'(map_n), 32'h1);

        // Clock enable low holds all state
        ena = 1'b0; rld_n = 1'b0;
        set(4'd1, 10'h55, 1'b0);
        repeat (3) tick();
        ena = 1'b1; rld_n = 1'b1;
        set(4'd14, 10'h0, 1'b0);
        chk("ena_upc", 32'(y), 32'h3);
        set(4'd7, 10'h0, 1'b1);
        chk("ena_r", 32'(y), 32'h0);
        set(4'd10, 10'h0, 1'b0);
        chk("ena_sp", 32'(y), 32'h0);
        chk("ena_full_n", 32'(full_n), 32'h1);

        // Unconditional counter load
        rld_n = 1'b0;
        set(4'd14, 10'd7, 1'b1);
        tick();                                 // r = 7, upc = 4
        rld_n = 1'b1;
        set(4'd7, 10'h0, 1'b1);
        chk("rld_r", 32'(y), 32'h7);

        // MicroPC wrap and carry-in hold
        ci = 1'b0;
        set(4'd3, 10'h3FF, 1'b0);
        tick();
        set(4'd14, 10'h0, 1'b1);
        chk("wrap_at_max", 32'(y), 32'h3FF);
        tick();
        chk("ci0_hold", 32'(y), 32'h3FF);
        ci = 1'b1;
        tick();
        chk("wrap_zero", 32'(y), 32'h0);

        // Asynchronous reset mid-sequence
        set(4'd1, 10'h10, 1'b0);
        tick();                                 // sp = 1, upc = 0x11
        rst_n = 1'b0;
        #1;
        chk("areset_y", 32'(y), 32'h0);
        chk("areset_full_n", 32'(full_n), 32'h1);
        rst_n = 1'b1;
        set(4'd14, 10'h0, 1'b0);
        chk("areset_upc", 32'(y), 32'h0);
        set(4'd10, 10'h0, 1'b0);
        chk("areset_sp", 32'(y), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
